// File: rtl/seq_divider_if.sv
// Handshake/result bundle for seq_divider.
// The master drives the start request and operands; the slave (the divider)
// returns busy/done and the held results.
// Optional feature macro: SIGNED_DIV_EN adds the signed_mode request bit.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef SIGNED_DIV_EN
  modport master (
    output start, dividend, divisor, signed_mode,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor, signed_mode,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock through a
// shift / trial-subtract datapath, start/busy/done handshake.
// Optional feature macro: SIGNED_DIV_EN (two's complement operands selected
// per request by signed_mode; magnitudes go through the same unsigned core and
// the signs are fixed up on the edge that enters DONE).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;       // partial remainder (raw dividend on /0)
  logic [WIDTH-1:0] quo_q;       // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dsr_q;       // divisor magnitude
  logic             zero_q;      // captured divisor was zero
  logic             q_neg_q;     // quotient must be negated at the end
  logic             r_neg_q;     // remainder must be negated at the end
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Shifted remainder needs WIDTH+1 bits (2*rem+1 can exceed WIDTH bits);
  // one more bit on top of the difference carries the borrow.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} + ~{2'b00, dsr_q} + {{(WIDTH+1){1'b0}}, 1'b1};
    borrow = diff[WIDTH+1];
    rem_d  = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], ~borrow};
  end

  // Operand conditioning at accept: magnitudes and result signs.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;

  always_comb begin
    div_zero = (bus.divisor == '0);
`ifdef SIGNED_DIV_EN
    a_neg = bus.signed_mode & bus.dividend[WIDTH-1];
    b_neg = bus.signed_mode & bus.divisor[WIDTH-1];
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
`endif
    a_mag = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag = b_neg ? (~bus.divisor  + 1'b1) : bus.divisor;
  end

  // Sign fix-up of the final step's results, applied on the DONE entry edge.
  // The most negative dividend over -1 yields magnitude 2^(WIDTH-1), which
  // is already the wrapped two's complement answer.
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  always_comb begin
    q_final = q_neg_q ? (~quo_d + 1'b1) : quo_d;
    r_final = r_neg_q ? (~rem_d + 1'b1) : rem_d;
  end

  // Control FSM with registered handshake outputs and result registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: every register here is control or a single word, so all are reset; there is no memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      zero_q      <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            count_q <= '0;
            quo_q   <= a_mag;
            dsr_q   <= b_mag;
            // On divide-by-zero the raw dividend is parked here as the remainder.
            rem_q   <= div_zero ? bus.dividend : '0;
            zero_q  <= div_zero;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (zero_q) begin
            // Divide-by-zero finishes one edge after accept.
            quotient_q  <= '1;
            remainder_q <= rem_q;
            dbz_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_ITER) begin
              quotient_q  <= q_final;
              remainder_q <= r_final;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
